// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

    // rel marks a break (F0-prefixed) event
    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } key_event_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/kb_event_fifo.sv
// First-word fall-through FIFO of decoded key events with sticky overflow.
module kb_event_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  key_event_t                   push_ev,
    input  logic                         pop,
    input  logic                         clr_ovf,
    output key_event_t                   head,
    output logic                         not_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    key_event_t    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;

    logic empty, full, do_pop, do_push, drop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FULL_CNT);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
            if (drop)         ovf_q <= 1'b1;
            else if (clr_ovf) ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_ev;
    end

    assign head      = empty ? '0 : mem_q[rd_ptr_q];
    assign not_empty = ~empty;
    assign count     = cnt_q;
    assign overflow  = ovf_q;

endmodule

// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: synchronise, filter, deframe, decode E0/F0 prefixes, queue events.
module ps2_kb_rx
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        PS2_CLK,
    input  logic                        DATA_PS2,
    input  logic                        rd_en,
    input  logic                        clr_ovf,
    output logic                        key_ready,
    output logic [7:0]                  key_code,
    output logic                        key_release,
    output logic                        key_ext,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        overflow,
    output logic                        frame_err
);

    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC - 1);

    logic [1:0]    clk_sync_q, data_sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic          clk_s, data_s, fall;

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          good_q, good_d;
    logic          err_q, err_d;

    logic          ext_pend_q, ext_pend_d;
    logic          rel_pend_q, rel_pend_d;
    logic          push;
    key_event_t    push_ev, head;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // Filtered clock flips once FILTER_LEN consecutive samples disagree with it
    always_comb begin
        filt_d    = filt_q;
        flt_cnt_d = '0;
        if (clk_s != filt_q) begin
            if (flt_cnt_q == FLT_MAX) filt_d    = clk_s;
            else                      flt_cnt_d = flt_cnt_q + 1'b1;
        end
    end

    assign fall = filt_q & ~filt_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_ok_d  = par_ok_q;
        tmr_d     = tmr_q;
        good_d    = 1'b0;
        err_d     = 1'b0;
        if (fall) begin
            tmr_d = '0;
            unique case (state_q)
                StIdle: begin
                    if (!data_s) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    shreg_d   = {data_s, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    par_ok_d = odd_parity_ok(shreg_q, data_s);
                    state_d  = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (data_s && par_ok_q) good_d = 1'b1;
                    else                    err_d  = 1'b1;
                end
            endcase
        end else if (state_q == StIdle) begin
            tmr_d = '0;
        end else if (tmr_q == TMO_MAX) begin
            tmr_d   = '0;
            state_d = StIdle;
            err_d   = 1'b1;
        end else begin
            tmr_d = tmr_q + 1'b1;
        end
    end

    // shreg_q is stable while good_q is high, so it serves as the received byte
    always_comb begin
        ext_pend_d = ext_pend_q;
        rel_pend_d = rel_pend_q;
        push       = 1'b0;
        push_ev    = '{ext: ext_pend_q, rel: rel_pend_q, code: shreg_q};
        if (good_q) begin
            if (shreg_q == PS2_EXT) begin
                ext_pend_d = 1'b1;
            end else if (shreg_q == PS2_BRK) begin
                rel_pend_d = 1'b1;
            end else begin
                push       = 1'b1;
                ext_pend_d = 1'b0;
                rel_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            flt_cnt_q   <= '0;
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            par_ok_q    <= 1'b0;
            tmr_q       <= '0;
            good_q      <= 1'b0;
            err_q       <= 1'b0;
            ext_pend_q  <= 1'b0;
            rel_pend_q  <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], PS2_CLK};
            data_sync_q <= {data_sync_q[0], DATA_PS2};
            filt_q      <= filt_d;
            flt_cnt_q   <= flt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            par_ok_q    <= par_ok_d;
            tmr_q       <= tmr_d;
            good_q      <= good_d;
            err_q       <= err_d;
            ext_pend_q  <= ext_pend_d;
            rel_pend_q  <= rel_pend_d;
        end
    end

    kb_event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_ev   (push_ev),
        .pop       (rd_en),
        .clr_ovf   (clr_ovf),
        .head      (head),
        .not_empty (key_ready),
        .count     (count),
        .overflow  (overflow)
    );

    assign key_code    = head.code;
    assign key_release = head.rel;
    assign key_ext     = head.ext;
    assign frame_err   = err_q;

endmodule

// File: tb/tb_ps2_kb_rx.sv
// Randomised and directed bench for ps2_kb_rx against a queue-based event model.
module tb_ps2_kb_rx;

    localparam int DEPTH = 8;
    localparam int FLT   = 4;
    localparam int TMO   = 2000;
    localparam int HALF  = 20;

    logic       clk = 1'b0;
    logic       rst, PS2_CLK, DATA_PS2, rd_en, clr_ovf;
    logic       key_ready, key_release, key_ext, overflow, frame_err;
    logic [7:0] key_code;
    logic [3:0] count;

    ps2_kb_rx #(
        .DEPTH       (DEPTH),
        .FILTER_LEN  (FLT),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PS2_CLK     (PS2_CLK),
        .DATA_PS2    (DATA_PS2),
        .rd_en       (rd_en),
        .clr_ovf     (clr_ovf),
        .key_ready   (key_ready),
        .key_code    (key_code),
        .key_release (key_release),
        .key_ext     (key_ext),
        .count       (count),
        .overflow    (overflow),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int err_cnt  = 0;

    // Model: event = {ext, rel, code}
    logic [9:0] m_q[$];
    bit         m_ext, m_rel, m_ovf;

    always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_outputs(input string tag);
        logic [9:0] h;
        h = (m_q.size() > 0) ? m_q[0] : 10'd0;
        check({tag, ".ready"}, key_ready, (m_q.size() > 0));
        check({tag, ".code"}, key_code, h[7:0]);
        check({tag, ".rel"}, key_release, h[8]);
        check({tag, ".ext"}, key_ext, h[9]);
        check({tag, ".count"}, count, m_q.size());
        check({tag, ".ovf"}, overflow, m_ovf);
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_rel = 1'b1;
        else begin
            if (m_q.size() < DEPTH) m_q.push_back({m_ext, m_rel, b});
            else m_ovf = 1'b1;
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ext = 1'b0;
        m_rel = 1'b0;
        m_ovf = 1'b0;
    endtask

    // mode 1: check 2-cycle ready latency on stop bit; mode 2: pulse rd_en in the push cycle.
    // Stop fall is seen after 2 sync edges plus FILTER_LEN samples; push lands 2 cycles later.
    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits,
                             input int mode);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            DATA_PS2 = f[i];
            repeat (HALF) @(negedge clk);
            PS2_CLK = 1'b0;
            if (i == 10 && mode == 1) begin
                repeat (FLT + 2) @(negedge clk);
                check("lat_before", key_ready, 1'b0);
                @(negedge clk);
                check("lat_ready", key_ready, 1'b1);
                repeat (HALF - FLT - 3) @(negedge clk);
            end else if (i == 10 && mode == 2) begin
                repeat (FLT + 2) @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
                repeat (HALF - FLT - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            PS2_CLK = 1'b1;
        end
        DATA_PS2 = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_bits(b, 1'b0, 11, 0);
        model_byte(b);
    endtask

    task automatic pop_ev(input string tag);
        check_outputs(tag);
        @(negedge clk) rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
        if (m_q.size() > 0) void'(m_q.pop_front());
    endtask

    initial begin
        int e0;
        logic [7:0] b;
        bit bad;
        rst = 1'b0; PS2_CLK = 1'b1; DATA_PS2 = 1'b1; rd_en = 1'b0; clr_ovf = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        check_outputs("reset");
        check("reset.ferr", frame_err, 1'b0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Single make code with latency check
        send_bits(8'h1C, 1'b0, 11, 1);
        model_byte(8'h1C);
        check_outputs("1c");
        pop_ev("1c_pop");
        check_outputs("1c_empty");

        // Extended break sequence
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h75);
        check_outputs("e0f075");
        check("e0f075.code", key_code, 8'h75);
        pop_ev("e0f075_pop");

        // Parity error then a clean retransmission
        e0 = err_cnt;
        send_bits(8'h29, 1'b1, 11, 0);
        check("par.err", err_cnt - e0, 1);
        check_outputs("par_bad");
        send_good(8'h29);
        check_outputs("par_good");
        pop_ev("par_pop");

        // Fill past depth, then simultaneous push/pop while full
        for (int i = 0; i < DEPTH + 1; i++) send_good(8'h10 + 8'(i));
        check_outputs("full");
        check("full.ovf", overflow, 1'b1);
        @(negedge clk) clr_ovf = 1'b1;
        @(negedge clk) clr_ovf = 1'b0;
        m_ovf = 1'b0;
        check_outputs("clr_ovf");
        send_bits(8'h20, 1'b0, 11, 2);
        void'(m_q.pop_front());
        model_byte(8'h20);
        check_outputs("pushpop");
        for (int i = 0; i < DEPTH; i++) pop_ev("drain");
        pop_ev("empty_pop");
        check_outputs("empty_after");

        // Timeout after start + 4 data bits
        e0 = err_cnt;
        send_bits(8'h3C, 1'b0, 5, 0);
        repeat (TMO + 100) @(negedge clk);
        check("tmo.err", err_cnt - e0, 1);
        check_outputs("tmo");
        send_good(8'h5A);
        check_outputs("tmo_5a");
        pop_ev("tmo_pop");

        // Randomised traffic
        for (int n = 0; n < 40; n++) begin
            e0 = $urandom_range(0, 9);
            if (e0 < 2) b = 8'hE0;
            else if (e0 < 4) b = 8'hF0;
            else begin
                b = 8'($urandom);
                if (b == 8'hE0 || b == 8'hF0) b = 8'h1A;
            end
            bad = ($urandom_range(0, 9) == 0);
            e0 = err_cnt;
            send_bits(b, bad, 11, 0);
            if (!bad) model_byte(b);
            check("rnd.err", err_cnt - e0, bad ? 1 : 0);
            check_outputs("rnd");
            if ($urandom_range(0, 2) == 0) pop_ev("rnd_pop");
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk) clr_ovf = 1'b1;
                @(negedge clk) clr_ovf = 1'b0;
                m_ovf = 1'b0;
            end
        end

        // Reset in the middle of a frame
        send_good(8'h12);
        send_bits(8'h44, 1'b0, 5, 0);
        @(negedge clk) rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("rst_mid");
        check("rst_mid.ferr", frame_err, 1'b0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        send_good(8'h66);
        check_outputs("rst_66");
        check("rst_66.code", key_code, 8'h66);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_kb_rx.md
PS2_KB_RX -- requirements
Module: ps2_kb_rx

Interface
REQ-001 SHALL have parameter DEPTH, default 8: key-event FIFO depth, a power of two, at least 2.
REQ-002 SHALL have parameter FILTER_LEN, default 4: consecutive equal synchronized PS2_CLK samples needed to change the filtered clock.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 100000: clk cycles without a PS2 falling edge before a partial frame is abandoned.
REQ-004 clk  input  1  system clock; the single clock domain.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 PS2_CLK  input  1  keyboard clock, asynchronous to clk.
REQ-007 DATA_PS2  input  1  keyboard data, asynchronous to clk.
REQ-008 rd_en  input  1  pops the FIFO head when key_ready=1.
REQ-009 clr_ovf  input  1  clears overflow.
REQ-010 key_ready  output  1  FIFO not empty.
REQ-011 key_code  output  8  scan code of the head event.
REQ-012 key_release  output  1  head event is a break (F0-prefixed).
REQ-013 key_ext  output  1  head event is extended (E0-prefixed).
REQ-014 count  output  $clog2(DEPTH+1)  number of events held.
REQ-015 overflow  output  1  sticky flag: an event was dropped.
REQ-016 frame_err  output  1  one-cycle pulse when a frame is discarded.

Function
REQ-017 PS2_CLK and DATA_PS2 SHALL each pass through a 2-flop synchronizer; PS2_CLK is then glitch-filtered per FILTER_LEN.
REQ-018 A falling edge SHALL be a filtered-clock 1->0 transition; DATA_PS2 is sampled (synchronized) on that cycle.
REQ-019 Frame FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-020 IDLE: a sampled 0 moves to DATA with the bit counter at 0; a sampled 1 stays in IDLE with no error.
REQ-021 DATA: SHALL shift 8 bits LSB-first, then move to PARITY.
REQ-022 PARITY: SHALL require odd parity over the 8 data bits plus the parity bit.
REQ-023 STOP: SHALL require a 1; the FSM returns to IDLE in every case.
REQ-024 A parity error or stop=0 SHALL discard the byte, pulse frame_err for one cycle, and leave decoder flags unchanged.
REQ-025 Timeout: in any state other than IDLE, TIMEOUT_CYC cycles with no falling edge SHALL force IDLE and pulse frame_err; the counter resets on every falling edge.
REQ-026 Decoder on a good byte:
  - 0xE0 sets ext_pend.
  - 0xF0 sets rel_pend.
  - Any other byte pushes the event {ext_pend, rel_pend, byte} and clears both flags.
REQ-027 Latency: key_ready SHALL assert exactly 2 clk cycles after the cycle that samples a valid stop bit, when the FIFO was empty.
REQ-028 The FIFO SHALL be first-word fall-through: key_code, key_release and key_ext show the head whenever key_ready=1, and are 0 when empty.
REQ-029 rd_en with an empty FIFO SHALL be ignored.
REQ-030 A push with the FIFO full and no pop in the same cycle SHALL drop the event and set overflow.
REQ-031 Push and pop in the same cycle SHALL both take effect, including when full, leaving count unchanged and overflow not set.
REQ-032 Read/write pointers SHALL wrap modulo DEPTH; count never exceeds DEPTH.
REQ-033 clr_ovf SHALL clear overflow next cycle; if clr_ovf and a drop coincide, set wins.

Reset
REQ-034 While rst=0, all of these SHALL be cleared:
  - FSM to IDLE;
  - synchronizers and filtered clock to 1;
  - counters, pointers, ext_pend and rel_pend to 0;
  - outputs key_ready, key_code, key_release, key_ext, count, overflow, frame_err to 0.
REQ-035 Reset asserted mid-frame SHALL discard the partial frame; after release, reception resumes at the next start bit.

Structure
REQ-036 A shared package ps2_pkg SHALL hold the FSM state enum, the key-event struct {ext, release, code[7:0]}, and the constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
REQ-037 The FIFO SHALL be a sub-module kb_event_fifo, parametrised by DEPTH and carrying the event struct.

Verification
REQ-038 The bench SHALL cover these directed scenarios:
  - Frame 0x1C, good parity -> key_ready=1 after 2 cycles, key_code=1C, key_release=0, key_ext=0; rd_en -> key_ready=0.
  - Bytes E0,F0,75 -> one event key_code=75, key_ext=1, key_release=1, count=1.
  - Frame 0x29 with parity flipped -> frame_err pulses once, count=0; then frame 0x29 good -> event 29.
  - DEPTH=8: push 9 events without reads -> count=8, overflow=1, head is event 1; pop and push in the same cycle -> count stays 8.
  - Clocks stopped after 4 data bits for TIMEOUT_CYC cycles -> frame_err pulse, FSM back to IDLE; next frame 0x5A received correctly.
  - rst=0 mid-frame -> all outputs 0; after release, frame 0x66 -> key_code=66.
